// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
// master drives operands and result acceptance; slave is the multiplier.
interface fp_mult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;

    modport master (
        output in_valid, a, b, rm, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, rm, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// Parametrised IEEE-754 multiplier: unpack/classify, multiply, round/pack.
// Three register stages, whole-pipe stall on output backpressure.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          reset,
    fp_mult_pipe_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EXP_W-1:0] E_MAXF = E_ONES - EXP_W'(1);
    localparam logic [EW-1:0]    BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0]    E_ONE  = EW'(1);
    localparam logic [W-1:0]     QNAN   =
        {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             v;
        logic             sgn;
        logic             rm;
        logic             spec;
        logic [W-1:0]     sres;
        logic [4:0]       sflg;
        logic [MAN_W:0]   ma;
        logic [MAN_W:0]   mb;
        logic [EXP_W-1:0] ea;
        logic [EXP_W-1:0] eb;
    } s1_t;

    typedef struct packed {
        logic         v;
        logic         sgn;
        logic         rm;
        logic         spec;
        logic [W-1:0] sres;
        logic [4:0]   sflg;
        logic [P-1:0] prod;
        logic [EW-1:0] esum;
    } s2_t;

    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    logic [W-1:0] res_d, res_q;
    logic [4:0]   flg_d, flg_q;
    logic         vld_q;
    logic         adv;

    assign adv          = !(vld_q && !io.out_ready);
    assign io.in_ready  = adv;
    assign io.out_valid = vld_q;
    assign io.result    = res_q;
    assign io.flags     = flg_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_nan, b_nan, a_snan, b_snan;
    logic a_inf, b_inf, a_zero, b_zero;

    assign ea     = io.a[W-2:MAN_W];
    assign eb     = io.b[W-2:MAN_W];
    assign fa     = io.a[MAN_W-1:0];
    assign fb     = io.b[MAN_W-1:0];
    assign a_nan  = (ea == E_ONES) && (fa != '0);
    assign b_nan  = (eb == E_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign a_inf  = (ea == E_ONES) && (fa == '0);
    assign b_inf  = (eb == E_ONES) && (fb == '0);
    // Zero exponent covers subnormals too: they are flushed to zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    always_comb begin
        s1_d      = '0;
        s1_d.v    = io.in_valid;
        s1_d.sgn  = io.a[W-1] ^ io.b[W-1];
        s1_d.rm   = io.rm;
        s1_d.ma   = {1'b1, fa};
        s1_d.mb   = {1'b1, fb};
        s1_d.ea   = ea;
        s1_d.eb   = eb;
        if (a_nan || b_nan) begin
            s1_d.spec = 1'b1;
            s1_d.sres = QNAN;
            s1_d.sflg = {a_snan || b_snan, 4'b0};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_d.spec = 1'b1;
            s1_d.sres = QNAN;
            s1_d.sflg = 5'b10000;
        end else if (a_inf || b_inf) begin
            s1_d.spec = 1'b1;
            s1_d.sres = {s1_d.sgn, E_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_d.spec = 1'b1;
            s1_d.sres = {s1_d.sgn, {(W-1){1'b0}}};
        end
    end

    always_comb begin
        s2_d      = '0;
        s2_d.v    = s1_q.v;
        s2_d.sgn  = s1_q.sgn;
        s2_d.rm   = s1_q.rm;
        s2_d.spec = s1_q.spec;
        s2_d.sres = s1_q.sres;
        s2_d.sflg = s1_q.sflg;
        s2_d.prod = P'(s1_q.ma) * P'(s1_q.mb);
        s2_d.esum = EW'(s1_q.ea) + EW'(s1_q.eb) - BIAS;
    end

    logic             msb, g, st, up;
    logic [MAN_W-1:0] frac;
    logic [MAN_W:0]   frac_r;
    logic [EW-1:0]    exp_n, exp_r;

    assign msb    = s2_q.prod[P-1];
    assign frac   = msb ? s2_q.prod[2*MAN_W:MAN_W+1]
                        : s2_q.prod[2*MAN_W-1:MAN_W];
    assign g      = msb ? s2_q.prod[MAN_W] : s2_q.prod[MAN_W-1];
    assign st     = msb ? |s2_q.prod[MAN_W-1:0]
                        : |s2_q.prod[MAN_W-2:0];
    assign up     = !s2_q.rm && g && (st || frac[0]);
    assign exp_n  = s2_q.esum + EW'(msb);
    assign frac_r = {1'b0, frac} + (MAN_W+1)'(up);
    assign exp_r  = exp_n + EW'(frac_r[MAN_W]);

    always_comb begin
        res_d = {s2_q.sgn, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        flg_d = {4'b0, g || st};
        if (s2_q.spec) begin
            res_d = s2_q.sres;
            flg_d = s2_q.sflg;
        end else if ($signed(exp_n) < $signed(E_ONE)) begin
            res_d = {s2_q.sgn, {(W-1){1'b0}}};
            flg_d = 5'b00011;
        end else if ($signed(exp_r) >= $signed(EMAX)) begin
            flg_d = 5'b00101;
            res_d = s2_q.rm ? {s2_q.sgn, E_MAXF, {MAN_W{1'b1}}}
                            : {s2_q.sgn, E_ONES, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            vld_q <= 1'b0;
            res_q <= '0;
            flg_q <= '0;
        end else if (adv) begin
            if (io.in_valid) s1_q <= s1_d;
            else             s1_q.v <= 1'b0;
            if (s1_q.v) s2_q <= s2_d;
            else        s2_q.v <= 1'b0;
            vld_q <= s2_q.v;
            if (s2_q.v) begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe (fp32 configuration) with an
// in-order scoreboard checked at every output handshake.
module tb_fp_mult_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) io();

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic r, input logic [31:0] er,
                        input logic [4:0] ef);
        int t;
        t = 0;
        io.in_valid = 1'b1;
        io.a  = av;
        io.b  = bv;
        io.rm = r;
        #1;
        while (!io.in_ready && t < 50) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("accept_wait", 64'(t < 50), 64'd1);
        sb.push_back({er, ef});
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic latency(input string tag);
        int cnt;
        cnt = 1;
        while (!io.out_valid && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(tag, 64'(cnt), 64'd3);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic        stall_prev;
        logic [31:0] prev_res;
        logic [4:0]  prev_flg;
        logic [36:0] expv;
        stall_prev = 1'b0;
        prev_res   = '0;
        prev_flg   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("stall_hold",
                        64'({io.out_valid, io.result, io.flags}),
                        64'({1'b1, prev_res, prev_flg}));
                if (io.out_valid && !io.out_ready)
                    chk("in_ready_blocked", 64'(io.in_ready), 64'd0);
                if (io.out_valid && io.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        expv = sb.pop_front();
                        chk("result_flags", 64'({io.result, io.flags}),
                            64'(expv));
                    end
                end
                stall_prev = io.out_valid && !io.out_ready;
                prev_res   = io.result;
                prev_flg   = io.flags;
            end
        end
    end

    initial begin
        reset        = 1'b1;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.rm        = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(io.out_valid), 64'd0);
        chk("reset_result", 64'(io.result), 64'd0);
        chk("reset_flags", 64'(io.flags), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000);
        latency("latency_first");
        drain();

        send(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 5'b00001);
        send(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 5'b00001);
        send(32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 5'b00001);
        send(32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 5'b00001);
        send(32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 5'b00001);
        send(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 5'b00101);
        send(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 5'b00101);
        send(32'hFF000000, 32'h7F000000, 1'b1, 32'hFF7FFFFF, 5'b00101);
        send(32'h7F800000, 32'h80000000, 1'b0, 32'h7FC00000, 5'b10000);
        send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000);
        send(32'h7F800000, 32'h00000001, 1'b0, 32'h7FC00000, 5'b10000);
        send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 5'b00000);
        send(32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 5'b00000);
        send(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 5'b00000);
        send(32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 5'b00011);
        drain();

        fork
            begin
                send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'b0);
                send(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 5'b0);
                send(32'h40400000, 32'h40400000, 1'b0, 32'h41100000, 5'b0);
                send(32'hBF800000, 32'h40000000, 1'b0, 32'hC0000000, 5'b0);
                send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 5'b0);
                send(32'h40A00000, 32'h40000000, 1'b0, 32'h41200000, 5'b0);
                send(32'h3F000000, 32'h3F000000, 1'b0, 32'h3E800000, 5'b0);
                send(32'hC0400000, 32'hC0000000, 1'b0, 32'h40C00000, 5'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                io.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                io.out_ready = 1'b1;
            end
        join
        drain();

        send(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 5'b0);
        send(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 5'b00001);
        send(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 5'b00101);
        reset = 1'b1;
        #1;
        chk("midflight_out_valid", 64'(io.out_valid), 64'd0);
        chk("midflight_result", 64'(io.result), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'b00000);
        latency("latency_after_reset");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
